// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-shot sequencer in front of the single-ported DataMemory.
// Each access is issued for one cycle and answered with a registered response one cycle later.
module dmem_arbiter #(
  parameter int SIZE = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic        byte0,
  input  logic        byte1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic        err0,
  output logic        err1,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_ByteORword,
  output logic        mem_ByteORwordS,
  output logic        mem_MemWrite,
  output logic        mem_EN,
  input  logic [31:0] mem_RD
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t      state_q, state_d;
  logic        last;
  logic        cmd_we, cmd_byte, cmd_id, cmd_err;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [31:0] rsp_data;

  logic        sel;
  logic        win_we, win_byte;
  logic [31:0] win_addr, win_wdata;

  // Misaligned words and anything past the end of the array never reach the memory.
  function automatic logic access_err(input logic is_byte, input logic [31:0] a);
    if (is_byte) return (a >= 32'(4 * SIZE));
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(SIZE));
  endfunction

  // On a tie the port that did not win last time goes first.
  assign sel       = (req0 && req1) ? ~last : req1;
  assign win_we    = sel ? we1    : we0;
  assign win_byte  = sel ? byte1  : byte0;
  assign win_addr  = sel ? addr1  : addr0;
  assign win_wdata = sel ? wdata1 : wdata0;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= IDLE;
      last      <= 1'b1;
      cmd_we    <= 1'b0;
      cmd_byte  <= 1'b0;
      cmd_id    <= 1'b0;
      cmd_err   <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      rsp_data  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && (req0 || req1)) begin
        cmd_we    <= win_we;
        cmd_byte  <= win_byte;
        cmd_addr  <= win_addr;
        cmd_wdata <= win_wdata;
        cmd_id    <= sel;
        cmd_err   <= access_err(win_byte, win_addr);
        last      <= sel;
      end
      if (state_q == ISSUE)
        rsp_data <= (!cmd_err && !cmd_we) ? mem_RD : '0;
    end
  end

  always_comb begin
    state_d         = state_q;
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    rvalid0         = 1'b0;
    rvalid1         = 1'b0;
    err0            = 1'b0;
    err1            = 1'b0;
    rdata0          = '0;
    rdata1          = '0;
    mem_A           = '0;
    mem_WD          = '0;
    mem_ByteORword  = 1'b0;
    mem_ByteORwordS = 1'b0;
    mem_MemWrite    = 1'b0;
    mem_EN          = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) state_d = ISSUE;
      end
      ISSUE: begin
        gnt0            = ~cmd_id;
        gnt1            = cmd_id;
        mem_A           = cmd_addr;
        mem_WD          = cmd_wdata;
        mem_ByteORword  = cmd_byte & ~cmd_we;
        mem_ByteORwordS = cmd_byte & cmd_we;
        mem_EN          = ~cmd_err;
        mem_MemWrite    = cmd_we & ~cmd_err;
        state_d         = RESP;
      end
      RESP: begin
        if (cmd_id) begin
          rvalid1 = 1'b1;
          err1    = cmd_err;
          rdata1  = rsp_data;
        end else begin
          rvalid0 = 1'b1;
          err0    = cmd_err;
          rdata0  = rsp_data;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a byte-array DataMemory stub on the pins and a transaction-level
// reference (shadow byte memory plus round-robin winner tracking) predicting every cycle.
module tb_dmem_arbiter;
  localparam int SIZE = 32;
  localparam int NB   = 4 * SIZE;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0, req1, we0, we1, byte0, byte1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
  logic [31:0] rdata0, rdata1;
  logic [31:0] mem_A, mem_WD, mem_RD;
  logic        mem_ByteORword, mem_ByteORwordS, mem_MemWrite, mem_EN;

  dmem_arbiter #(.SIZE(SIZE)) dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1), .byte0(byte0), .byte1(byte1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .err0(err0), .err1(err1),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_ByteORword(mem_ByteORword),
    .mem_ByteORwordS(mem_ByteORwordS), .mem_MemWrite(mem_MemWrite), .mem_EN(mem_EN),
    .mem_RD(mem_RD)
  );

  always #5 CLK = ~CLK;

  // DataMemory stub: little-endian bytes, combinational read, write on the rising edge.
  bit [7:0] dm [NB];

  function automatic logic [31:0] dm_word(input int a);
    return {dm[a+3], dm[a+2], dm[a+1], dm[a]};
  endfunction

  always_comb begin
    mem_RD = '0;
    if (mem_A < 32'(NB)) begin
      if (mem_ByteORword) mem_RD = {24'h0, dm[int'(mem_A)]};
      else                mem_RD = dm_word(int'({mem_A[31:2], 2'b00}));
    end
  end

  always @(posedge CLK) begin
    if (mem_EN && mem_MemWrite && mem_A < 32'(NB)) begin
      if (mem_ByteORwordS) dm[int'(mem_A)] <= mem_WD[7:0];
      else for (int i = 0; i < 4; i++) dm[int'({mem_A[31:2], 2'b00}) + i] <= mem_WD[8*i +: 8];
    end
  end

  // Reference model state
  bit [7:0]    rm [NB];
  logic        rlast;
  logic        f_we [2];
  logic        f_byte [2];
  logic [31:0] f_addr [2];
  logic [31:0] f_wd [2];
  logic [31:0] obs_rd;
  logic        obs_first;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_port(input int p, input logic w, input logic b,
                          input logic [31:0] a, input logic [31:0] d);
    f_we[p] = w; f_byte[p] = b; f_addr[p] = a; f_wd[p] = d;
    if (p == 0) begin we0 = w; byte0 = b; addr0 = a; wdata0 = d; end
    else        begin we1 = w; byte1 = b; addr1 = a; wdata1 = d; end
  endtask

  // Rejection rule and memory effect of one access, in plain arithmetic.
  task automatic ref_access(input int p, output logic e, output logic [31:0] rd);
    longint a;
    a  = longint'(f_addr[p]);
    rd = '0;
    if (f_byte[p]) e = (a >= NB);
    else           e = (a % 4 != 0) || (a / 4 >= SIZE);
    if (!e) begin
      if (f_we[p]) begin
        if (f_byte[p]) rm[int'(a)] = f_wd[p][7:0];
        else for (int i = 0; i < 4; i++) rm[int'(a) + i] = f_wd[p][8*i +: 8];
      end else if (f_byte[p]) rd = {24'h0, rm[int'(a)]};
      else rd = {rm[int'(a)+3], rm[int'(a)+2], rm[int'(a)+1], rm[int'(a)]};
    end
  endtask

  // Raise the chosen requests together and follow every grant/response they cause.
  task automatic run(input logic r0, input logic r1);
    logic        pend [2];
    int          w;
    logic        e;
    logic [31:0] rd;
    bit          first;
    first = 1;
    @(posedge CLK); #1;
    req0 = r0; req1 = r1;
    pend[0] = r0; pend[1] = r1;
    while (pend[0] || pend[1]) begin
      @(posedge CLK); #1;
      w = (pend[0] && pend[1]) ? (rlast ? 0 : 1) : (pend[1] ? 1 : 0);
      rlast = (w == 1);
      pend[w] = 0;
      if (w == 0) req0 = 1'b0; else req1 = 1'b0;
      ref_access(w, e, rd);
      @(negedge CLK);
      if (first) obs_first = gnt1;
      first = 0;
      chk("gnt0", gnt0, w == 0);
      chk("gnt1", gnt1, w == 1);
      chk("mem_A", mem_A, f_addr[w]);
      chk("mem_WD", mem_WD, f_wd[w]);
      chk("mem_EN", mem_EN, !e);
      chk("mem_MemWrite", mem_MemWrite, f_we[w] && !e);
      chk("mem_ByteORword", mem_ByteORword, f_byte[w] && !f_we[w]);
      chk("mem_ByteORwordS", mem_ByteORwordS, f_byte[w] && f_we[w]);
      @(negedge CLK);
      chk("rvalid0", rvalid0, w == 0);
      chk("rvalid1", rvalid1, w == 1);
      chk("err", (w == 0) ? err0 : err1, e);
      chk("rdata", (w == 0) ? rdata0 : rdata1, rd);
      chk("other_port_quiet", {rdata0 | rdata1} & ((w == 0) ? rdata1 : rdata0), 0);
      obs_rd = (w == 0) ? rdata0 : rdata1;
      @(negedge CLK);
      chk("idle_quiet", {gnt0, gnt1, rvalid0, rvalid1, mem_EN, mem_MemWrite}, 0);
    end
  endtask

  initial begin
    logic        r0, r1, w, b;
    logic [31:0] a;
    RST = 1'b0; rlast = 1'b1;
    req0 = 0; req1 = 0;
    set_port(0, 0, 0, 0, 0);
    set_port(1, 0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_ctrl", {gnt0, gnt1, rvalid0, rvalid1, err0, err1,
                       mem_MemWrite, mem_EN, mem_ByteORword, mem_ByteORwordS}, 0);
    chk("reset_data", mem_A | mem_WD | rdata0 | rdata1, 0);
    RST = 1'b1;
    @(negedge CLK);
    chk("release_ctrl", {gnt0, gnt1, rvalid0, rvalid1, mem_EN}, 0);

    // Basic write then reads from the other port
    set_port(0, 1, 0, 32'h10, 32'hDEADBEEF); run(1, 0);
    set_port(1, 0, 0, 32'h10, 0);            run(0, 1);
    chk("word_read_literal", obs_rd, 32'hDEADBEEF);
    set_port(1, 0, 1, 32'h13, 0);            run(0, 1);
    chk("byte_read_literal", obs_rd, 32'h000000DE);

    // Collisions: port 0 first after port 1 won last; port 1 first after port 0 won last
    set_port(0, 0, 0, 32'h10, 0);
    set_port(1, 1, 0, 32'h40, 32'h12345678);
    run(1, 1);
    chk("collide_first_p0", obs_first, 1'b0);
    run(1, 0);
    run(1, 1);
    chk("collide_first_p1", obs_first, 1'b1);

    // Trapped accesses
    set_port(0, 0, 0, 32'h2, 0);            run(1, 0);
    set_port(1, 1, 1, 32'h80, 32'hAA);      run(0, 1);
    set_port(0, 1, 0, 32'h7C, 32'h0BAD0BAD); run(1, 0);
    set_port(1, 1, 0, 32'h80, 32'h55);      run(0, 1);
    set_port(0, 0, 0, 32'h7C, 0);           run(1, 0);
    chk("last_word_unchanged", obs_rd, 32'h0BAD0BAD);

    // Byte merges
    set_port(0, 1, 0, 32'h0, 32'hBEEF1234); run(1, 0);
    set_port(0, 1, 1, 32'h0, 32'h000000FF); run(1, 0);
    set_port(0, 1, 1, 32'h2, 32'hABCDEFFF); run(1, 0);
    set_port(1, 0, 0, 32'h0, 0);            run(0, 1);
    chk("byte_merge_literal", obs_rd, 32'hBEFF12FF);

    // Reset during the ISSUE cycle of a write
    set_port(0, 1, 0, 32'h20, 32'hCAFEF00D);
    @(posedge CLK); #1; req0 = 1'b1;
    @(posedge CLK); #1;
    chk("pre_reset_gnt0", gnt0, 1'b1);
    chk("pre_reset_write", mem_MemWrite, 1'b1);
    #2 RST = 1'b0;
    #1;
    chk("async_gnt0", gnt0, 1'b0);
    chk("async_write", {mem_MemWrite, mem_EN}, 0);
    req0 = 1'b0;
    rlast = 1'b1;
    @(posedge CLK);
    @(negedge CLK); RST = 1'b1;
    repeat (3) begin
      @(negedge CLK);
      chk("no_rvalid_after_reset", {rvalid0, rvalid1, gnt0, gnt1}, 0);
    end
    set_port(1, 0, 0, 32'h20, 0); run(0, 1);
    chk("aborted_write_literal", obs_rd, 32'h0);

    // Randomized traffic
    repeat (60) begin
      r0 = 1'($urandom % 2);
      r1 = 1'($urandom % 2);
      if (!r0 && !r1) r0 = 1'b1;
      for (int p = 0; p < 2; p++) begin
        w = 1'($urandom % 2);
        b = 1'($urandom % 2);
        a = 32'($urandom_range(0, NB + 8));
        if (!b && ($urandom % 4 != 0)) a[1:0] = 2'b00;
        if ($urandom % 12 == 0) a = $urandom;
        set_port(p, w, b, a, $urandom);
      end
      run(r0, r1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
